// File: rtl/adsr_envelope.sv
// Gated ADSR amplitude envelope applied to 12-bit offset-binary PCM ahead of the PWM DAC.
// Define ADSR_EXP_RELEASE_EN for an exponential (level >> 4) release instead of the linear RELEASE_STEP.
module adsr_envelope #(
    parameter int TICK_DIV      = 4000,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 2,
    parameter int SUSTAIN_LEVEL = 160,
    parameter int RELEASE_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [11:0] pcm_in,
    output logic [11:0] pcm_out,
    output logic [7:0]  env_level,
    output logic [2:0]  state,
    output logic        active
);

    localparam int              CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [8:0]      ATK_W     = 9'(ATTACK_STEP);
    localparam logic [8:0]      DEC_W     = 9'(DECAY_STEP);
    localparam logic [8:0]      SUS_W     = 9'(SUSTAIN_LEVEL);
    localparam logic [7:0]      REL_W     = 8'(RELEASE_STEP);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    adsr_state_t        state_r;
    adsr_state_t        state_nxt_s;
    logic [CNT_W-1:0]   tick_cnt_r;
    logic               tick_s;
    logic [7:0]         level_r;
    logic [7:0]         level_nxt_s;
    logic [8:0]         attack_sum_s;
    logic [7:0]         rel_dec_s;
    logic [11:0]        pcm_out_r;
    logic [11:0]        pcm_nxt_s;
    logic               active_r;
    logic signed [12:0] sample_s;
    logic signed [20:0] gain_s;
    logic signed [20:0] prod_s;

    assign tick_s       = (tick_cnt_r == TICK_LAST);
    assign attack_sum_s = {1'b0, level_r} + ATK_W;

    // Release decrement: fixed step, or level/16 with a floor of one so the tail still reaches zero.
`ifdef ADSR_EXP_RELEASE_EN
    assign rel_dec_s = (level_r[7:4] == 4'd0) ? 8'd1 : {4'd0, level_r[7:4]};
`else
    assign rel_dec_s = REL_W;
`endif

    // Next state/level: gate changes take priority over the tick-driven level update.
    always_comb begin
        state_nxt_s = state_r;
        level_nxt_s = level_r;
        case (state_r)
            ST_IDLE: begin
                if (gate) begin
                    state_nxt_s = ST_ATTACK;
                end else begin
                    level_nxt_s = 8'd0;
                end
            end
            ST_ATTACK: begin
                if (!gate) begin
                    state_nxt_s = ST_RELEASE;
                end else if (tick_s) begin
                    if (attack_sum_s >= 9'd255) begin
                        level_nxt_s = 8'd255;
                        state_nxt_s = ST_DECAY;
                    end else begin
                        level_nxt_s = attack_sum_s[7:0];
                    end
                end else begin
                    level_nxt_s = level_r;
                end
            end
            ST_DECAY: begin
                if (!gate) begin
                    state_nxt_s = ST_RELEASE;
                end else if (tick_s) begin
                    // 9-bit compare keeps SUSTAIN_LEVEL + DECAY_STEP from wrapping
                    if ({1'b0, level_r} <= (SUS_W + DEC_W)) begin
                        level_nxt_s = SUS_W[7:0];
                        state_nxt_s = ST_SUSTAIN;
                    end else begin
                        level_nxt_s = level_r - DEC_W[7:0];
                    end
                end else begin
                    level_nxt_s = level_r;
                end
            end
            ST_SUSTAIN: begin
                if (!gate) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    level_nxt_s = level_r;
                end
            end
            ST_RELEASE: begin
                if (gate) begin
                    state_nxt_s = ST_ATTACK;
                end else if (tick_s) begin
                    if (level_r <= rel_dec_s) begin
                        level_nxt_s = 8'd0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        level_nxt_s = level_r - rel_dec_s;
                    end
                end else begin
                    level_nxt_s = level_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                level_nxt_s = 8'd0;
            end
        endcase
    end

    // Scaling: (pcm - 2048) * level / 256 with floor, re-centred on mid-scale.
    always_comb begin
        sample_s  = $signed({1'b0, pcm_in}) - 13'sd2048;
        gain_s    = $signed({13'd0, level_r});
        prod_s    = $signed({{8{sample_s[12]}}, sample_s}) * gain_s;
        pcm_nxt_s = 12'(prod_s >>> 8) + 12'd2048;
    end

    // Tick divider, envelope state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
            state_r    <= ST_IDLE;
            level_r    <= 8'd0;
            pcm_out_r  <= 12'd2048;
            active_r   <= 1'b0;
        end else begin
            tick_cnt_r <= tick_s ? '0 : (tick_cnt_r + CNT_W'(1));
            state_r    <= state_nxt_s;
            level_r    <= level_nxt_s;
            pcm_out_r  <= pcm_nxt_s;
            active_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    assign pcm_out   = pcm_out_r;
    assign env_level = level_r;
    assign state     = state_r;
    assign active    = active_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed scoreboard bench for adsr_envelope (TICK_DIV=4); honours ADSR_EXP_RELEASE_EN when defined.
module tb_adsr_envelope;

    logic        clk = 1'b0;
    logic        rst;
    logic        gate;
    logic [11:0] pcm_in;
    logic [11:0] pcm_out;
    logic [7:0]  env_level;
    logic [2:0]  state;
    logic        active;

    logic        gate2;
    logic [11:0] pcm_in2;
    logic [11:0] pcm_out2;
    logic [7:0]  env_level2;
    logic [2:0]  state2;
    logic        active2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;
    exp_t sb_q[$];

    adsr_envelope #(.TICK_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .gate(gate), .pcm_in(pcm_in),
        .pcm_out(pcm_out), .env_level(env_level), .state(state), .active(active)
    );

    adsr_envelope #(.TICK_DIV(4), .ATTACK_STEP(3), .RELEASE_STEP(5)) u_dut2 (
        .clk(clk), .rst(rst), .gate(gate2), .pcm_in(pcm_in2),
        .pcm_out(pcm_out2), .env_level(env_level2), .state(state2), .active(active2)
    );

    always #5 clk = ~clk;

    // sel: 0 level, 1 state, 2 pcm_out, 3 active, 4 level2, 5 state2, 6 active2
    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {24'd0, env_level};
            1:       return {29'd0, state};
            2:       return {20'd0, pcm_out};
            3:       return {31'd0, active};
            4:       return {24'd0, env_level2};
            5:       return {29'd0, state2};
            6:       return {31'd0, active2};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic int rel_next(input int lvl, input int step);
        int d;
`ifdef ADSR_EXP_RELEASE_EN
        d = lvl >> 4;
        if (d == 0) d = 1;
`else
        d = step;
`endif
        return (lvl <= d) ? 0 : lvl - d;
    endfunction

    task automatic push(input string tag, input int sel, input int exp);
        sb_q.push_back('{tag, sel, exp});
    endtask

    task automatic check_all();
        exp_t        it;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            obs = observe(it.sel);
            checks++;
            assert (obs === 32'(it.exp)) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", it.tag, obs, it.exp, cyc);
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to_tick();
        do begin
            clk_step();
        end while (cyc % 4 != 0);
    endtask

    initial begin
        int lvl;
        int st;
        int lvl2;

        rst = 1'b1; gate = 1'b1; pcm_in = 12'd4095; gate2 = 1'b0; pcm_in2 = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        push("rst_level", 0, 0); push("rst_state", 1, 0);
        push("rst_pcm", 2, 2048); push("rst_active", 3, 0);
        push("rst_level2", 4, 0); push("rst_state2", 5, 0);
        check_all();

        rst = 1'b0;
        push("start_state", 1, 1); push("start_active", 3, 1); push("start_level", 0, 0);
        clk_step();
        check_all();

        lvl = 0;
        for (int k = 1; k <= 32; k++) begin
            lvl = (lvl + 8 >= 255) ? 255 : lvl + 8;
            st  = (lvl == 255) ? 2 : 1;
            push("attack_level", 0, lvl); push("attack_state", 1, st);
            run_to_tick();
            check_all();
        end

        pcm_in = 12'd4095; push("scale255_max", 2, 4087); clk_step(); check_all();
        pcm_in = 12'd0;    push("scale255_min", 2, 8);    clk_step(); check_all();
        pcm_in = 12'd2048; push("scale255_mid", 2, 2048); clk_step(); check_all();

        st = 2;
        while (st == 2) begin
            if (lvl <= 162) begin
                lvl = 160;
                st  = 3;
            end else begin
                lvl = lvl - 2;
            end
            push("decay_level", 0, lvl); push("decay_state", 1, st);
            run_to_tick();
            check_all();
        end

        repeat (100) begin
            push("sustain_level", 0, 160); push("sustain_state", 1, 3);
            run_to_tick();
            check_all();
        end

        pcm_in = 12'd4095; push("scale160_max", 2, 3327); clk_step(); check_all();
        pcm_in = 12'd0;    push("scale160_min", 2, 768);  clk_step(); check_all();
        push("sustain_hold", 0, 160); run_to_tick(); check_all();

        gate = 1'b0;
        push("rel_enter_state", 1, 4); push("rel_enter_level", 0, 160);
        clk_step();
        check_all();
        lvl = 160;
        while (lvl > 100) begin
            lvl = rel_next(lvl, 1);
            push("release_level", 0, lvl); push("release_state", 1, 4);
            run_to_tick();
            check_all();
        end

        gate = 1'b1;
        push("retrig_state", 1, 1); push("retrig_level", 0, lvl);
        clk_step();
        check_all();
        repeat (3) begin
            lvl = lvl + 8;
            push("retrig_attack", 0, lvl); push("retrig_attack_state", 1, 1);
            run_to_tick();
            check_all();
        end

        repeat (3) clk_step();
        gate = 1'b0;
        push("collide_state", 1, 4); push("collide_level", 0, lvl);
        clk_step();
        check_all();

        while (lvl > 0) begin
            lvl = rel_next(lvl, 1);
            st  = (lvl == 0) ? 0 : 4;
            push("tail_level", 0, lvl); push("tail_state", 1, st);
            push("tail_active", 3, (lvl != 0) ? 1 : 0);
            run_to_tick();
            check_all();
        end
        push("idle_hold_level", 0, 0); push("idle_hold_state", 1, 0);
        run_to_tick();
        check_all();
        pcm_in = 12'd4095; push("scale0", 2, 2048); clk_step(); check_all();

        gate2 = 1'b1;
        push("d2_attack_state", 5, 1); push("d2_attack_active", 6, 1);
        clk_step();
        check_all();
        push("d2_level3", 4, 3); run_to_tick(); check_all();
        gate2 = 1'b0;
        push("d2_rel_state", 5, 4); push("d2_rel_level", 4, 3);
        clk_step();
        check_all();
        lvl2 = 3;
        while (lvl2 > 0) begin
            lvl2 = rel_next(lvl2, 5);
            push("d2_rel_tail", 4, lvl2); push("d2_rel_tail_state", 5, (lvl2 == 0) ? 0 : 4);
            run_to_tick();
            check_all();
        end
        push("d2_idle_active", 6, 0); check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Upstream neighbour of the PWM audio DAC: takes the 12-bit unsigned PCM from the tone generators (sine/triangle) and applies a gated ADSR amplitude envelope.
- Output PCM drives the DAC, so a button press produces a shaped note instead of a constant tone.
- Runs in the 40 MHz pixel clock domain; envelope advances on a divided tick.

Parameters:
- TICK_DIV, 4000, clk cycles per envelope tick (40 MHz / 4000 = 10 kHz); legal range >= 2.
- ATTACK_STEP, 8, level increment per tick in ATTACK (1..255).
- DECAY_STEP, 2, level decrement per tick in DECAY (1..255).
- SUSTAIN_LEVEL, 160, sustain level (0..255).
- RELEASE_STEP, 1, level decrement per tick in RELEASE (1..255).

Ports:
- clk, input, 1, system clock (40 MHz).
- rst, input, 1, synchronous reset, active-high.
- gate, input, 1, note on while high; already synchronous to clk.
- pcm_in, input, 12, unsigned offset-binary PCM; mid-scale = 2048.
- pcm_out, output, 12, enveloped PCM to the DAC; registered.
- env_level, output, 8, current envelope level.
- state, output, 3, state code: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- active, output, 1, high when state != IDLE.

Behaviour:
- Reset, on rising clk while rst=1:
  - state = IDLE, env_level = 0, pcm_out = 2048, active = 0.
  - Tick counter cleared to 0.
  - Reset asserted mid-note aborts the note immediately.
- Tick generation:
  - Free-running counter 0..TICK_DIV-1, wraps to 0.
  - tick = 1 for one cycle when the counter equals TICK_DIV-1, so the first tick after reset occurs on cycle TICK_DIV.
- Gate transitions: evaluated every cycle, independent of tick. Transitions take effect on the next clock edge.
  - IDLE and gate=1 -> ATTACK.
  - ATTACK, DECAY or SUSTAIN and gate=0 -> RELEASE.
  - RELEASE and gate=1 -> ATTACK (retrigger). Attack continues from the current level, with no reset to 0.
  - If a gate transition and a tick occur in the same cycle, the transition wins and env_level is unchanged that cycle.
- Level updates, applied only on tick when no gate transition is taken:
  - ATTACK: if level + ATTACK_STEP >= 255, level = 255 and state -> DECAY; else level += ATTACK_STEP.
  - DECAY: if level <= SUSTAIN_LEVEL + DECAY_STEP, level = SUSTAIN_LEVEL and state -> SUSTAIN; else level -= DECAY_STEP.
    - Compute in 9 bits so the step never underflows.
    - If SUSTAIN_LEVEL = 255, DECAY exits on the first tick.
  - SUSTAIN: level held.
  - RELEASE: if level <= RELEASE_STEP, level = 0 and state -> IDLE; else level -= RELEASE_STEP.
  - IDLE: level held at 0.
- Scaling, with 1-cycle latency from pcm_in to pcm_out:
  - s = pcm_in - 2048, 13-bit signed.
  - p = s * env_level, 21-bit signed, env_level zero-extended.
  - pcm_out = 2048 + (p >>> 8), arithmetic shift (floor).
  - Result always lies within 8..4087, so no clamp is needed.
  - Uses env_level as registered in the same cycle as pcm_in is sampled.
- Boundary checks:
  - level 0 -> pcm_out = 2048 for any input.
  - level 255: pcm_in 4095 -> 4087; pcm_in 0 -> 8.

Optional Feature:
- Macro: ADSR_EXP_RELEASE_EN.
- Defined: RELEASE uses an exponential decrement.
  - dec = level >> 4, forced to a minimum of 1.
  - If level <= dec, level = 0 and state -> IDLE; else level -= dec.
  - RELEASE_STEP is ignored.
- Undefined: RELEASE uses the linear RELEASE_STEP rule above.
- All other behaviour is identical either way.

Test Plan:
- Bench settings: TICK_DIV=4, macro undefined unless stated.
- Reset: hold rst 3 cycles with gate=1 and pcm_in=4095 -> state 0, env_level 0, pcm_out 2048, active 0. After release, ATTACK on the next edge.
- Full attack/decay: gate=1 held -> env_level 8,16,…,248, then 255 on tick 32 -> DECAY. Decay 253,251,… -> clamps to 160 in SUSTAIN. Holds 160 over 100 ticks.
- Scaling: level 255 with pcm_in 4095/0/2048 -> pcm_out 4087/8/2048 one cycle later. Level 160 with pcm_in 4095 -> 2048 + (2047*160 >>> 8) = 3327.
- Release and retrigger: drop gate in SUSTAIN -> RELEASE, level 160→159→… by 1 per tick. Raise gate at level 100 -> ATTACK from 100 (108, 116, …).
- Collision: gate falls in the same cycle as a tick in ATTACK -> state RELEASE with env_level unchanged that cycle. Release from level 3 with RELEASE_STEP=5 -> level 0, IDLE.
- ADSR_EXP_RELEASE_EN defined: release from 160 -> 150, 141, 133, …. Tail decrements by 1 below 16, reaching 0/IDLE; no underflow to 255.
